// File: rtl/perspective_divide_viewport.sv
// Perspective divide and viewport transform: clip-space (x,y,z,w) -> screen pixels + NDC depth.
// Input bus packing (low to high): x[DW-1:0] = x, then y, z, w in successive DW-bit slices.
module perspective_divide_viewport #(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned FRACBITS   = 16,
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 240,
    parameter int unsigned COORDWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*DATAWIDTH-1:0]  x,
    input  logic                    i_dv,
    output logic                    o_ready,
    output logic [COORDWIDTH-1:0]   o_sx,
    output logic [COORDWIDTH-1:0]   o_sy,
    output logic [DATAWIDTH-1:0]    o_depth,
    output logic                    o_clipped,
    output logic                    o_dv
);
    localparam int unsigned DW    = DATAWIDTH;
    localparam int unsigned PW    = 2*DATAWIDTH + 1;
    localparam int unsigned CNT_W = $clog2(DATAWIDTH);

    // Dividend 2^(2*FRACBITS): the upper part seeds the remainder, the lower DW bits are shifted in.
    localparam logic [PW-1:0]        DIVIDEND  = PW'(1) << (2*FRACBITS);
    localparam logic [DW:0]          DIV_HI    = DIVIDEND[PW-1:DW];
    localparam logic [DW-1:0]        DIV_LO    = DIVIDEND[DW-1:0];
    localparam logic signed [PW-1:0] ONE_P     = PW'(1) << FRACBITS;
    localparam logic signed [DW-1:0] ONE_D     = DW'(1) << FRACBITS;
    localparam logic signed [DW-1:0] NEG_ONE_D = -ONE_D;
    localparam logic signed [PW-1:0] HALF_W    = PW'(SCREEN_W / 2);
    localparam logic signed [PW-1:0] HALF_H    = PW'(SCREEN_H / 2);

    typedef enum logic [2:0] {IDLE, DIVIDE, SCALE, VIEWPORT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   accept_c;
    logic signed [DW-1:0]   x_in, y_in, z_in, w_in;
    logic                   w_pos_c;

    logic signed [DW-1:0]   vx_q, vy_q, vz_q;
    logic [DW-1:0]          w_q, rem_q, dvd_q, quot_q;
    logic                   ovf_q;
    logic [CNT_W-1:0]       cnt_q;
    logic signed [DW-1:0]   xn_q, yn_q, zn_q;

    logic [DW:0]            rem_sh_c;
    logic [DW-1:0]          rem_sub_c;
    logic                   q_bit_c;
    logic [DW-1:0]          recip_c;
    logic signed [PW-1:0]   recip_p, px_c, py_c, pz_c, sx_p, sy_p;
    logic                   clip_c;

    assign x_in    = x[DW-1:0];
    assign y_in    = x[2*DW-1:DW];
    assign z_in    = x[3*DW-1:2*DW];
    assign w_in    = x[4*DW-1:3*DW];
    assign w_pos_c = !w_in[DW-1] && (w_in != '0);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_c  = {rem_q, dvd_q[DW-1]};
        rem_sub_c = DW'(rem_sh_c - {1'b0, w_q});
        q_bit_c   = (rem_sh_c >= {1'b0, w_q});
    end

    // NDC scaling and viewport mapping, evaluated in a wide signed domain.
    always_comb begin
        recip_c = ovf_q ? '1 : quot_q;
        recip_p = $signed(PW'(recip_c));
        px_c    = PW'(vx_q) * recip_p;
        py_c    = PW'(vy_q) * recip_p;
        pz_c    = PW'(vz_q) * recip_p;
        sx_p    = (PW'(xn_q) + ONE_P) * HALF_W;
        sy_p    = (ONE_P - PW'(yn_q)) * HALF_H;
        clip_c  = (xn_q < NEG_ONE_D) | (xn_q > ONE_D) |
                  (yn_q < NEG_ONE_D) | (yn_q > ONE_D) |
                  (zn_q < NEG_ONE_D) | (zn_q > ONE_D);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        o_ready  = 1'b0;
        accept_c = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                o_ready  = 1'b1;
                accept_c = i_dv;
                if (i_dv) state_d = w_pos_c ? DIVIDE : DONE;
                else      state_d = IDLE;
            end
            DIVIDE:   if (cnt_q == CNT_W'(DW-1)) state_d = SCALE;
            SCALE:    state_d = VIEWPORT;
            VIEWPORT: state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vx_q      <= '0;
            vy_q      <= '0;
            vz_q      <= '0;
            w_q       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quot_q    <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            xn_q      <= '0;
            yn_q      <= '0;
            zn_q      <= '0;
            o_sx      <= '0;
            o_sy      <= '0;
            o_depth   <= '0;
            o_clipped <= 1'b0;
            o_dv      <= 1'b0;
        end else begin
            o_dv <= (state_d == DONE);
            if (accept_c) begin
                vx_q   <= x_in;
                vy_q   <= y_in;
                vz_q   <= z_in;
                w_q    <= w_in;
                rem_q  <= DIV_HI[DW-1:0];
                dvd_q  <= DIV_LO;
                quot_q <= '0;
                cnt_q  <= '0;
                // Quotient cannot fit in DW bits when the seed remainder already reaches w.
                ovf_q  <= ({1'b0, w_in} <= DIV_HI);
                if (!w_pos_c) begin
                    o_sx      <= '0;
                    o_sy      <= '0;
                    o_depth   <= '0;
                    o_clipped <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    DIVIDE: begin
                        rem_q  <= q_bit_c ? rem_sub_c : rem_sh_c[DW-1:0];
                        quot_q <= {quot_q[DW-2:0], q_bit_c};
                        dvd_q  <= dvd_q << 1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                    SCALE: begin
                        xn_q <= DW'(px_c >>> FRACBITS);
                        yn_q <= DW'(py_c >>> FRACBITS);
                        zn_q <= DW'(pz_c >>> FRACBITS);
                    end
                    VIEWPORT: begin
                        o_sx      <= COORDWIDTH'(sx_p >>> FRACBITS);
                        o_sy      <= COORDWIDTH'(sy_p >>> FRACBITS);
                        o_depth   <= zn_q;
                        o_clipped <= clip_c;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/perspective_divide_viewport.md
Name: perspective_divide_viewport

Overview:
- Downstream neighbour of the 4x4 matrix-vector multiplier in RenderPipeline; consumes the clip-space vector (x, y, z, w) it produces.
- Computes the reciprocal of w with an iterative restoring divider, then scales x, y and z to NDC.
- Maps NDC x/y to integer screen pixels and passes NDC z through as depth.
- Flags vertices that fall outside the view volume; the rasteriser setup stage consumes the output.

Parameters:
- DATAWIDTH, 32, width of signed fixed-point input/NDC values.
- FRACBITS, 16, fractional bits of the fixed-point format; ONE = 1<<FRACBITS.
- SCREEN_W, 320, screen width in pixels; must be even.
- SCREEN_H, 240, screen height in pixels; must be even.
- COORDWIDTH, 16, width of signed screen-coordinate outputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- x  in  4 x DATAWIDTH  clip-space vector [x,y,z,w], signed QFRACBITS
- i_dv  in  1  input valid
- o_ready  out  1  block can accept input this cycle
- o_sx  out  COORDWIDTH  signed screen x
- o_sy  out  COORDWIDTH  signed screen y
- o_depth  out  DATAWIDTH  signed NDC z, QFRACBITS
- o_clipped  out  1  vertex outside view volume
- o_dv  out  1  output valid, one-cycle pulse

Behaviour:
- One clock. Reset is synchronous and active-high. Reset is sampled on posedge clk and has priority over all other inputs.
- Reset values: state IDLE, o_dv 0, o_clipped 0, o_sx/o_sy/o_depth 0, all internal registers 0.
- Reset mid-operation aborts the in-flight vertex; no o_dv is produced for it.
- States: IDLE, DIVIDE, SCALE, VIEWPORT, DONE.
- o_ready (combinational): 1 in IDLE and DONE, 0 otherwise.
- Accept: when i_dv && o_ready at posedge, register x/y/z/w.
  - If w <= 0 (signed), go to DONE with o_clipped=1 and o_sx=o_sy=o_depth=0.
  - Otherwise go to DIVIDE.
- i_dv while o_ready=0 is ignored; inputs are not buffered.
- DIVIDE: restoring division, one quotient bit per cycle, exactly DATAWIDTH cycles.
  - recip = floor(2^(2*FRACBITS) / w), unsigned DATAWIDTH bits.
  - If the true quotient exceeds 2^DATAWIDTH-1, saturate recip to all-ones.
- SCALE (1 cycle), computed for x, y and z:
  - n = (v * recip) >>> FRACBITS.
  - Signed v times zero-extended recip, full-width product, arithmetic shift, truncated to DATAWIDTH.
- VIEWPORT (1 cycle):
  - sx = ((xn + ONE) * (SCREEN_W/2)) >>> FRACBITS.
  - sy = ((ONE - yn) * (SCREEN_H/2)) >>> FRACBITS.
  - Both truncated to COORDWIDTH; y axis points down.
  - o_clipped = (xn < -ONE) | (xn > ONE) | (yn < -ONE) | (yn > ONE) | (zn < -ONE) | (zn > ONE).
  - Coordinates are still output when clipped.
- DONE (1 cycle): o_dv=1. Outputs are registered and held stable until the next DONE or reset.
  - If i_dv in DONE, accept the new vertex (back-to-back).
  - Otherwise return to IDLE.
- Latency: o_dv is high exactly DATAWIDTH+3 cycles after the accepting edge for w > 0, and 1 cycle after for w <= 0.
- Throughput: one vertex per DATAWIDTH+3 cycles.

Test Plan:
- Nominal: x=0x10000, y=0, z=0x8000, w=0x20000 -> o_dv at accept+35: o_sx=240, o_sy=120, o_depth=0x4000, o_clipped=0.
- Centre: x=y=z=0, w=0x10000 -> o_sx=160, o_sy=120, o_depth=0, o_clipped=0.
- Off-screen: x=0x30000, y=0, z=0, w=0x10000 -> xn=0x30000, o_sx=640, o_clipped=1.
- Degenerate w=0 and w=0xFFFF0000 -> o_dv one cycle after accept, o_clipped=1, all coords 0, no DIVIDE cycles.
- Back-to-back: i_dv held high with two vertices -> o_ready low during DIVIDE/SCALE/VIEWPORT, second vertex accepted in DONE, two o_dv pulses 35 cycles apart, results match reference model.
- Reset mid-DIVIDE (cycle 10) -> next cycle: state IDLE, o_ready=1, o_dv=0, outputs 0, no spurious o_dv afterwards.
